// File: rtl/wb_master_if_if.sv
// Wishbone classic-cycle bus bundle between the CPU-side master bridge and a slave.
// The master modport drives the request side; the slave modport drives terminations.
interface wb_master_if_if #(
  parameter int DW   = 32,
  parameter int AW   = 32,
  parameter int SELW = DW/8
);
  logic [DW-1:0]   wishbone_data_i;
  logic            wishbone_ack_i;
  logic            wishbone_err_i;
  logic            wishbone_rty_i;
  logic [AW-1:0]   wishbone_addr_o;
  logic [DW-1:0]   wishbone_data_o;
  logic            wishbone_we_o;
  logic [SELW-1:0] wishbone_sel_o;
  logic            wishbone_stb_o;
  logic            wishbone_cyc_o;

  modport master (
    input  wishbone_data_i, wishbone_ack_i, wishbone_err_i, wishbone_rty_i,
    output wishbone_addr_o, wishbone_data_o, wishbone_we_o, wishbone_sel_o,
           wishbone_stb_o, wishbone_cyc_o
  );

  modport slave (
    output wishbone_data_i, wishbone_ack_i, wishbone_err_i, wishbone_rty_i,
    input  wishbone_addr_o, wishbone_data_o, wishbone_we_o, wishbone_sel_o,
           wishbone_stb_o, wishbone_cyc_o
  );
endinterface

// File: rtl/wb_master_if.sv
// Wishbone classic master bridge for the CPU memory stage with ERR/RTY handling.
// Define WB_TIMEOUT_EN to build the BUSY watchdog that aborts after TIMEOUT cycles.
module wb_master_if #(
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int SELW      = DW/8,
  parameter int STALLW    = 6,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STALLW-1:0] stall_i,
  input  logic              flush_i,
  input  logic              cpu_ce_i,
  input  logic [DW-1:0]     cpu_data_i,
  input  logic [AW-1:0]     cpu_addr_i,
  input  logic              cpu_we_i,
  input  logic [SELW-1:0]   cpu_sel_i,
  output logic [DW-1:0]     cpu_data_o,
  output logic              cpu_err_o,
  output logic              stallreq,
  wb_master_if_if.master    wb
);
  localparam int RCW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int TW  = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BUSY, RETRY, WAIT_FOR_STALL} state_e;

  state_e          state_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   data_q;
  logic            we_q;
  logic [SELW-1:0] sel_q;
  logic            cyc_q;
  logic [DW-1:0]   rd_buf_q;
  logic            err_buf_q;
  logic [RCW-1:0]  retry_cnt_q;

  logic ack, err, rty, timeout, retry_ok, err_term, stalled;

  assign ack      = wb.wishbone_ack_i;
  assign err      = wb.wishbone_err_i;
  assign rty      = wb.wishbone_rty_i;
  assign stalled  = |stall_i;
  assign retry_ok = retry_cnt_q < RCW'(MAX_RETRY);
  // Anything that ends the transfer as an error, once ack has been ruled out
  assign err_term = err | (rty & ~retry_ok) | (~rty & timeout);

`ifdef WB_TIMEOUT_EN
  logic [TW-1:0] tmo_cnt_q;

  // Counter is only live in BUSY, so entering BUSY always starts it from zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         tmo_cnt_q <= '0;
    else if (state_q != BUSY)         tmo_cnt_q <= '0;
    else if (!(ack | err | rty | flush_i)) tmo_cnt_q <= tmo_cnt_q + 1'b1;
  end

  assign timeout = (state_q == BUSY) && (tmo_cnt_q == TW'(TIMEOUT - 1));
`else
  logic [TW-1:0] unused_tmo;
  assign unused_tmo = '0;
  assign timeout    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      cyc_q       <= 1'b0;
      rd_buf_q    <= '0;
      err_buf_q   <= 1'b0;
      retry_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (cpu_ce_i && !flush_i) begin
          addr_q      <= cpu_addr_i;
          data_q      <= cpu_data_i;
          we_q        <= cpu_we_i;
          sel_q       <= cpu_sel_i;
          cyc_q       <= 1'b1;
          retry_cnt_q <= '0;
          rd_buf_q    <= '0;
          err_buf_q   <= 1'b0;
          state_q     <= BUSY;
        end
        BUSY: begin
          if (ack || err_term || (!rty && flush_i)) begin
            addr_q <= '0;
            data_q <= '0;
            we_q   <= 1'b0;
            sel_q  <= '0;
            cyc_q  <= 1'b0;
          end
          if (ack) begin
            rd_buf_q  <= we_q ? '0 : wb.wishbone_data_i;
            err_buf_q <= 1'b0;
            state_q   <= stalled ? WAIT_FOR_STALL : IDLE;
          end else if (err_term) begin
            rd_buf_q  <= '0;
            err_buf_q <= 1'b1;
            state_q   <= stalled ? WAIT_FOR_STALL : IDLE;
          end else if (rty) begin
            // Keep the request latched so the retry re-issues it unchanged
            cyc_q       <= 1'b0;
            retry_cnt_q <= retry_cnt_q + 1'b1;
            state_q     <= RETRY;
          end else if (flush_i) begin
            rd_buf_q  <= '0;
            err_buf_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        RETRY: if (flush_i) begin
          addr_q  <= '0;
          data_q  <= '0;
          we_q    <= 1'b0;
          sel_q   <= '0;
          cyc_q   <= 1'b0;
          state_q <= IDLE;
        end else begin
          cyc_q   <= 1'b1;
          state_q <= BUSY;
        end
        WAIT_FOR_STALL: if (!stalled) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  logic [DW-1:0] data_c;
  logic          err_c;
  logic          stall_c;

  always_comb begin
    data_c  = '0;
    err_c   = 1'b0;
    stall_c = 1'b0;
    case (state_q)
      IDLE:  stall_c = cpu_ce_i & ~flush_i;
      BUSY: begin
        if (ack)           data_c  = we_q ? '0 : wb.wishbone_data_i;
        else if (err_term) err_c   = 1'b1;
        else if (rty)      stall_c = 1'b1;
        else               stall_c = ~flush_i;
      end
      RETRY: stall_c = ~flush_i;
      WAIT_FOR_STALL: begin
        data_c = rd_buf_q;
        err_c  = err_buf_q;
      end
      default: ;
    endcase
  end

  // Reset forces the CPU-facing outputs quiet even if a request is pending
  assign cpu_data_o = rst ? data_c : '0;
  assign cpu_err_o  = rst & err_c;
  assign stallreq   = rst & stall_c;

  assign wb.wishbone_addr_o = addr_q;
  assign wb.wishbone_data_o = data_q;
  assign wb.wishbone_we_o   = we_q;
  assign wb.wishbone_sel_o  = sel_q;
  assign wb.wishbone_stb_o  = cyc_q;
  assign wb.wishbone_cyc_o  = cyc_q;
endmodule

// File: tb/tb_wb_master_if.sv
// Directed bench for wb_master_if: read, write+stall, retry, timeout, flush, async reset.
// Built with MAX_RETRY=2 and TIMEOUT=16; the watchdog checks follow WB_TIMEOUT_EN.
module tb_wb_master_if;
  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall_i;
  logic        flush_i, cpu_ce_i, cpu_we_i, cpu_err_o, stallreq;
  logic [31:0] cpu_data_i, cpu_addr_i, cpu_data_o;
  logic [3:0]  cpu_sel_i;
  int          n_tests = 0;
  int          n_fail  = 0;

  wb_master_if_if #(.DW(32), .AW(32), .SELW(4)) wb ();

  wb_master_if #(.DW(32), .AW(32), .SELW(4), .STALLW(6), .MAX_RETRY(2), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .cpu_ce_i(cpu_ce_i),
    .cpu_data_i(cpu_data_i), .cpu_addr_i(cpu_addr_i), .cpu_we_i(cpu_we_i),
    .cpu_sel_i(cpu_sel_i), .cpu_data_o(cpu_data_o), .cpu_err_o(cpu_err_o),
    .stallreq(stallreq), .wb(wb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: step just past the rising edge so inputs change away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [31:0] a, input logic we, input logic [31:0] d, input logic [3:0] s);
    cpu_ce_i = 1'b1; cpu_addr_i = a; cpu_we_i = we; cpu_data_i = d; cpu_sel_i = s;
  endtask

  task automatic wb_idle();
    wb.wishbone_ack_i = 1'b0; wb.wishbone_err_i = 1'b0; wb.wishbone_rty_i = 1'b0;
  endtask

  int bad;

  initial begin
    rst = 1'b0; stall_i = '0; flush_i = 1'b0; cpu_ce_i = 1'b1; cpu_we_i = 1'b0;
    cpu_data_i = '0; cpu_addr_i = 32'h1; cpu_sel_i = '0;
    wb.wishbone_data_i = '0; wb_idle();
    #2;
    chk("rst_stallreq", stallreq, 0);
    chk("rst_cyc", wb.wishbone_cyc_o, 0);
    chk("rst_addr", wb.wishbone_addr_o, 0);
    tick();
    chk("rst_cyc_edge", wb.wishbone_cyc_o, 0);
    chk("rst_data_o", cpu_data_o, 0);
    cpu_ce_i = 1'b0;
    rst = 1'b1;

    // zero-wait read
    tick();
    req(32'h0000_0100, 1'b0, 32'h0, 4'hF);
    #1 chk("rd_idle_stallreq", stallreq, 1);
    tick();
    cpu_ce_i = 1'b0;
    wb.wishbone_ack_i = 1'b1; wb.wishbone_data_i = 32'hDEADBEEF;
    #1;
    chk("rd_cyc", wb.wishbone_cyc_o, 1);
    chk("rd_stb", wb.wishbone_stb_o, 1);
    chk("rd_addr", wb.wishbone_addr_o, 32'h100);
    chk("rd_ack_stallreq", stallreq, 0);
    chk("rd_ack_data", cpu_data_o, 32'hDEADBEEF);
    chk("rd_ack_err", cpu_err_o, 0);
    tick();
    wb_idle();
    #1;
    chk("rd_done_cyc", wb.wishbone_cyc_o, 0);
    chk("rd_done_addr", wb.wishbone_addr_o, 0);
    chk("rd_done_sel", wb.wishbone_sel_o, 0);
    chk("rd_done_data", cpu_data_o, 0);

    // write, ack while stalled, stall holds 3 WAIT cycles
    req(32'h0000_0200, 1'b1, 32'hCAFEF00D, 4'b0011);
    #1 chk("wr_idle_stallreq", stallreq, 1);
    tick();
    cpu_ce_i = 1'b0;
    #1;
    chk("wr_we", wb.wishbone_we_o, 1);
    chk("wr_sel", wb.wishbone_sel_o, 4'b0011);
    chk("wr_wdata", wb.wishbone_data_o, 32'hCAFEF00D);
    wb.wishbone_ack_i = 1'b1; wb.wishbone_data_i = 32'h5555AAAA; stall_i = 6'b000100;
    #1;
    chk("wr_ack_stallreq", stallreq, 0);
    chk("wr_ack_data", cpu_data_o, 0);
    tick();
    wb_idle();
    req(32'h0000_0300, 1'b0, 32'h0, 4'hF);
    for (int i = 1; i <= 3; i++) begin
      if (i == 3) stall_i = '0;
      #1;
      chk($sformatf("wr_wait%0d_stallreq", i), stallreq, 0);
      chk($sformatf("wr_wait%0d_data", i), cpu_data_o, 0);
      chk($sformatf("wr_wait%0d_cyc", i), wb.wishbone_cyc_o, 0);
      tick();
    end

    // back in IDLE with the pending request: retry twice then ack (read, stalled)
    #1 chk("rty_idle_stallreq", stallreq, 1);
    for (int k = 1; k <= 2; k++) begin
      tick();
      cpu_ce_i = 1'b0;
      wb.wishbone_rty_i = 1'b1;
      #1;
      chk($sformatf("rty%0d_cyc", k), wb.wishbone_cyc_o, 1);
      chk($sformatf("rty%0d_stallreq", k), stallreq, 1);
      chk($sformatf("rty%0d_err", k), cpu_err_o, 0);
      tick();
      wb_idle();
      #1;
      chk($sformatf("rty%0d_gap_stb", k), wb.wishbone_stb_o, 0);
      chk($sformatf("rty%0d_gap_addr", k), wb.wishbone_addr_o, 32'h300);
      chk($sformatf("rty%0d_gap_stallreq", k), stallreq, 1);
    end
    tick();
    wb.wishbone_ack_i = 1'b1; wb.wishbone_data_i = 32'h1234_5678; stall_i = 6'b000001;
    #1;
    chk("rty_ack_stb", wb.wishbone_stb_o, 1);
    chk("rty_ack_addr", wb.wishbone_addr_o, 32'h300);
    chk("rty_ack_data", cpu_data_o, 32'h1234_5678);
    chk("rty_ack_err", cpu_err_o, 0);
    chk("rty_ack_stallreq", stallreq, 0);
    tick();
    wb_idle(); stall_i = '0; wb.wishbone_data_i = '0;
    #1;
    chk("rty_wait_rdbuf", cpu_data_o, 32'h1234_5678);
    chk("rty_wait_stallreq", stallreq, 0);
    tick();
    #1 chk("rty_idle_data", cpu_data_o, 0);

    // retry exhaustion: third rty becomes an error
    req(32'h0000_0400, 1'b0, 32'h0, 4'hF);
    for (int k = 1; k <= 2; k++) begin
      tick();
      cpu_ce_i = 1'b0;
      wb.wishbone_rty_i = 1'b1;
      tick();
      wb_idle();
    end
    tick();
    wb.wishbone_rty_i = 1'b1;
    #1;
    chk("rtyx_err", cpu_err_o, 1);
    chk("rtyx_stallreq", stallreq, 0);
    chk("rtyx_data", cpu_data_o, 0);
    tick();
    wb_idle();
    #1;
    chk("rtyx_done_cyc", wb.wishbone_cyc_o, 0);
    chk("rtyx_done_addr", wb.wishbone_addr_o, 0);
    chk("rtyx_done_err", cpu_err_o, 0);

    // silent slave
    req(32'h0000_0500, 1'b0, 32'h0, 4'hF);
    tick();
    cpu_ce_i = 1'b0;
`ifdef WB_TIMEOUT_EN
    for (int i = 1; i < 16; i++) begin
      #1;
      if (i == 15) chk("tmo_b15_stallreq", stallreq, 1);
      tick();
    end
    #1;
    chk("tmo_b16_cyc", wb.wishbone_cyc_o, 1);
    chk("tmo_b16_err", cpu_err_o, 1);
    chk("tmo_b16_stallreq", stallreq, 0);
    tick();
    #1;
    chk("tmo_done_cyc", wb.wishbone_cyc_o, 0);
    chk("tmo_done_err", cpu_err_o, 0);
`else
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (wb.wishbone_stb_o !== 1'b1 || stallreq !== 1'b1 || cpu_err_o !== 1'b0) bad++;
      tick();
    end
    chk("notmo_hold_100", bad, 0);
    flush_i = 1'b1;
    #1 chk("notmo_flush_stallreq", stallreq, 0);
    tick();
    flush_i = 1'b0;
    #1 chk("notmo_flush_cyc", wb.wishbone_cyc_o, 0);
`endif

    // flush in third BUSY cycle, late ack ignored
    req(32'h0000_0600, 1'b0, 32'h0, 4'hF);
    tick();
    cpu_ce_i = 1'b0;
    tick();
    tick();
    flush_i = 1'b1;
    #1;
    chk("fl_stallreq", stallreq, 0);
    chk("fl_err", cpu_err_o, 0);
    tick();
    flush_i = 1'b0;
    wb.wishbone_ack_i = 1'b1; wb.wishbone_data_i = 32'hBADBAD00;
    #1;
    chk("fl_idle_cyc", wb.wishbone_cyc_o, 0);
    chk("fl_late_data", cpu_data_o, 0);
    chk("fl_late_err", cpu_err_o, 0);
    tick();
    wb_idle();
    #1;
    chk("fl_after_cyc", wb.wishbone_cyc_o, 0);
    chk("fl_after_data", cpu_data_o, 0);

    // ack beats flush
    req(32'h0000_0700, 1'b0, 32'h0, 4'hF);
    tick();
    cpu_ce_i = 1'b0;
    wb.wishbone_ack_i = 1'b1; wb.wishbone_data_i = 32'h0F0F0F0F; flush_i = 1'b1;
    #1;
    chk("ackfl_data", cpu_data_o, 32'h0F0F0F0F);
    chk("ackfl_stallreq", stallreq, 0);
    tick();
    wb_idle(); flush_i = 1'b0;

    // err beats rty: bus fully dropped, address not held
    req(32'h0000_0800, 1'b0, 32'h0, 4'hF);
    tick();
    cpu_ce_i = 1'b0;
    wb.wishbone_err_i = 1'b1; wb.wishbone_rty_i = 1'b1;
    #1;
    chk("errrty_err", cpu_err_o, 1);
    chk("errrty_stallreq", stallreq, 0);
    tick();
    wb_idle();
    #1;
    chk("errrty_addr", wb.wishbone_addr_o, 0);
    chk("errrty_cyc", wb.wishbone_cyc_o, 0);

    // asynchronous reset between edges while BUSY
    req(32'h0000_0900, 1'b1, 32'h11112222, 4'hF);
    tick();
    cpu_ce_i = 1'b0;
    #1 chk("ar_busy_cyc", wb.wishbone_cyc_o, 1);
    #1 rst = 1'b0;
    #1;
    chk("ar_cyc", wb.wishbone_cyc_o, 0);
    chk("ar_stb", wb.wishbone_stb_o, 0);
    chk("ar_addr", wb.wishbone_addr_o, 0);
    chk("ar_stallreq", stallreq, 0);
    rst = 1'b1;
    tick();
    #1 chk("ar_post_stallreq", stallreq, 0);
    cpu_ce_i = 1'b1;
    #1 chk("ar_post_idle_accept", stallreq, 1);
    cpu_ce_i = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench timeout");
  end
endmodule

// File: doc/wb_master_if.md
# wb_master_if

Parametrised Wishbone classic-cycle master bridge between the CPU memory stage and the Wishbone bus; successor to the fixed 32-bit bus interface. It adds configurable data, address and stall widths, slave error (ERR) and retry (RTY) termination, a bounded retry count, and an optional bus-timeout watchdog. A CPU access is held by `stallreq` until the transfer terminates. A read result or error is then held while the pipeline remains stalled.

## Interface
- DW, 32, data width; multiple of 8
- AW, 32, address width
- SELW, DW/8, byte-select width
- STALLW, 6, width of ctrl stall vector
- MAX_RETRY, 3, RTY terminations retried before reporting error; 0..15
- TIMEOUT, 256, BUSY cycles before watchdog abort; >=2

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- stall_i  in  STALLW  pipeline stall vector from ctrl
- flush_i  in  1  pipeline flush from ctrl
- cpu_ce_i  in  1  access request
- cpu_data_i  in  DW  write data
- cpu_addr_i  in  AW  address
- cpu_we_i  in  1  1=write
- cpu_sel_i  in  SELW  byte selects
- cpu_data_o  out  DW  read data (combinational)
- cpu_err_o  out  1  access terminated in error (combinational)
- stallreq  out  1  stall request to ctrl (combinational)
- wishbone_data_i  in  DW  slave read data
- wishbone_ack_i / wishbone_err_i / wishbone_rty_i  in  1 each  slave terminations
- wishbone_addr_o  out  AW  registered
- wishbone_data_o  out  DW  registered
- wishbone_we_o  out  1  registered
- wishbone_sel_o  out  SELW  registered
- wishbone_stb_o / wishbone_cyc_o  out  1 each  registered, always equal

## Operation
- Reset (rst=0, asynchronous): state IDLE, all registered outputs 0, rd_buf=0, err_buf=0, retry_cnt=0, tmo_cnt=0. Combinational outputs are 0 while reset is asserted.
- Counter widths: retry_cnt is $clog2(MAX_RETRY+1) bits; tmo_cnt is $clog2(TIMEOUT) bits.
- **IDLE**
  - Condition: cpu_ce_i=1 and flush_i=0.
  - Registered actions: latch addr, data, we and sel onto the bus outputs; set stb=cyc=1; clear retry_cnt, tmo_cnt, rd_buf and err_buf; go to BUSY.
  - Combinational: stallreq=1 when the condition holds, otherwise 0. cpu_data_o=0 and cpu_err_o=0 in all cases.
- **BUSY**: one termination per cycle, in priority ack > err > rty > timeout > flush.
  - **ack**
    - Drop all bus outputs to 0.
    - rd_buf is loaded from wishbone_data_i if the latched wishbone_we_o is 0; otherwise rd_buf=0.
    - Combinational in the same cycle: stallreq=0; cpu_data_o = latched we ? 0 : wishbone_data_i; cpu_err_o=0.
  - **err**
    - Drop all bus outputs to 0; rd_buf=0; err_buf=1.
    - Combinational in the same cycle: stallreq=0, cpu_err_o=1, cpu_data_o=0.
  - **rty with retry_cnt<MAX_RETRY**
    - Drop stb/cyc only; addr, data, we and sel are held.
    - Increment retry_cnt; go to RETRY.
    - stallreq=1.
  - **rty with retry_cnt==MAX_RETRY**: handled exactly as err.
  - **timeout**: tmo_cnt reaches TIMEOUT-1 with no termination. Handled exactly as err.
  - **flush**
    - Drop all bus outputs to 0; rd_buf=0; err_buf=0; go to IDLE.
    - stallreq=0 in this cycle, no error reported.
    - A late ack, err or rty arriving in IDLE is ignored.
  - **No termination**: stallreq=1, cpu_data_o=0; increment tmo_cnt.
  - **Next state** after ack, err, retry exhaustion or timeout: WAIT_FOR_STALL if stall_i!=0 in that cycle, else IDLE.
- **RETRY**: one cycle with stb=cyc=0.
  - Normally: reassert stb/cyc, clear tmo_cnt, go to BUSY; stallreq=1.
  - With flush_i=1: clear the bus outputs, go to IDLE; stallreq=0.
- **WAIT_FOR_STALL**
  - Combinational: stallreq=0, cpu_data_o=rd_buf, cpu_err_o=err_buf.
  - Go to IDLE when stall_i==0; a new request is accepted only from IDLE.

## Timing
- stb/cyc rise one cycle after the request is seen in IDLE.
- A slave that asks ack in the first stb cycle completes the access in 2 cycles: one stallreq=1 cycle, then the data cycle.
- Each retry adds 2 cycles: one RETRY cycle plus one new BUSY cycle minimum.
- Back-to-back accesses: after ack with stall_i=0, the next request is seen in IDLE on the following cycle. Minimum spacing is 2 cycles per access.
- stb and cyc are never high in IDLE, RETRY or WAIT_FOR_STALL.
- Bus outputs change only on clock edges.
- Simultaneous ack and flush: ack wins and the result is delivered.
- Simultaneous err and rty: err wins.

## Configuration
- WB_TIMEOUT_EN defined: the tmo_cnt watchdog is present, and a transfer is aborted as error after TIMEOUT cycles in BUSY.
- WB_TIMEOUT_EN undefined:
  - No counter is built, and the TIMEOUT parameter is ignored.
  - BUSY waits indefinitely for ack, err, rty or flush.

## Test plan
- **Zero-wait read**
  - Stimulus: addr 0x0000_0100, slave acks in the first stb cycle with 0xDEADBEEF.
  - Required: stallreq=1 for exactly 1 cycle; cpu_data_o=0xDEADBEEF with stallreq=0 in the ack cycle; all bus outputs 0 on the next edge.
- **Write, then stall**
  - Stimulus: sel 4'b0011, ack arrives while stall_i=6'b000100, stall holds 3 cycles.
  - Required: WAIT_FOR_STALL for 3 cycles with cpu_data_o=0 and stallreq=0; IDLE after stall_i=0.
- **Retry**
  - Stimulus: MAX_RETRY=2; slave gives rty, rty, then ack with 0x1234_5678.
  - Required: stb low for exactly 1 cycle between attempts; addr held throughout; cpu_data_o=0x1234_5678 and cpu_err_o=0.
  - Variant: three consecutive rty gives cpu_err_o=1 in the third rty cycle.
- **Timeout**
  - Stimulus: TIMEOUT=16, macro defined, slave never responds.
  - Required: stb/cyc drop after the 16th BUSY cycle; cpu_err_o=1 for 1 cycle.
  - Macro undefined: stb stays high for 100 cycles.
- **Flush mid-BUSY**
  - Stimulus: flush_i=1 in the 3rd BUSY cycle; ack arrives one cycle later.
  - Required: IDLE on the next edge; cpu_err_o=0; the late ack is ignored, with no data delivered and the state unchanged.
- **Asynchronous reset mid-BUSY**
  - Stimulus: rst=0 between clock edges.
  - Required: stb/cyc/addr go to 0 immediately, before any clock edge; after release, state is IDLE with stallreq=0.
